// File: rtl/mem_arbiter.sv
// Byte-serial memory/IO bus arbiter between instruction fetch and load/store.
// Optional MEM_ARB_FAIR_EN: ties alternate between ports instead of fixed data priority.
module mem_arbiter #(
  parameter logic [31:0] IO_BASE    = 32'h30000,
  parameter int          INST_BYTES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        clear,
  input  logic        inst_valid,
  input  logic [31:0] inst_addr,
  output logic        inst_ready,
  output logic [31:0] inst_res,
  input  logic        data_valid,
  input  logic        data_wr,
  input  logic [2:0]  data_type,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_value,
  output logic        data_ready,
  output logic [31:0] data_res,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  typedef enum logic [1:0] {IDLE, INST_RD, DATA_RD, DATA_WR} state_e;

  localparam logic [1:0] INST_LAST = 2'(INST_BYTES - 1);

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [1:0]  last_q, last_d;
  logic [1:0]  size_q, size_d;
  logic        sext_q, sext_d;
  logic        io_q, io_d;
  logic        clr_q, clr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] res_q, res_d;
  logic [31:0] mem_a_q, mem_a_d;
  logic [7:0]  mem_dout_q, mem_dout_d;
  logic        mem_wr_q, mem_wr_d;
  logic        inst_ready_q, inst_ready_d;
  logic        data_ready_q, data_ready_d;
  logic [31:0] inst_res_q, inst_res_d;
  logic [31:0] data_res_q, data_res_d;
`ifdef MEM_ARB_FAIR_EN
  logic        lastg_q, lastg_d;  // 0 = inst served last, 1 = data
`endif

  logic        data_io, data_ok, inst_ok, grant_data;
  logic [1:0]  nxt;
  logic [31:0] asm_w, ext_w;

  assign data_io = (data_addr[17:16] == IO_BASE[17:16]);
  // A port whose ready is still high is holding a stale valid; ignore it.
  assign data_ok = data_valid && !data_ready_q && !(data_wr && data_io && io_buffer_full);
  assign inst_ok = inst_valid && !inst_ready_q;
`ifdef MEM_ARB_FAIR_EN
  assign grant_data = data_ok && (!inst_ok || !lastg_q);
`else
  assign grant_data = data_ok;
`endif
  assign nxt = cnt_q + 2'd1;

  always_comb begin
    asm_w = res_q;
    asm_w[{cnt_q, 3'b000} +: 8] = mem_din;
    case (size_q)
      2'b00:   ext_w = sext_q ? {{24{asm_w[7]}}, asm_w[7:0]}   : {24'h0, asm_w[7:0]};
      2'b01:   ext_w = sext_q ? {{16{asm_w[15]}}, asm_w[15:0]} : {16'h0, asm_w[15:0]};
      default: ext_w = asm_w;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_d       = last_q;
    size_d       = size_q;
    sext_d       = sext_q;
    io_d         = io_q;
    clr_d        = clr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    res_d        = res_q;
    mem_a_d      = mem_a_q;
    mem_dout_d   = mem_dout_q;
    mem_wr_d     = mem_wr_q;
    inst_ready_d = inst_ready_q;
    data_ready_d = data_ready_q;
    inst_res_d   = inst_res_q;
    data_res_d   = data_res_q;
`ifdef MEM_ARB_FAIR_EN
    lastg_d      = lastg_q;
`endif
    if (rdy) begin
      inst_ready_d = 1'b0;
      data_ready_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (!clear && grant_data) begin
            state_d = data_wr ? DATA_WR : DATA_RD;
            addr_d  = data_addr;
            mem_a_d = data_addr;
            wdata_d = data_value;
            cnt_d   = 2'd0;
            size_d  = data_type[1:0];
            sext_d  = data_type[2];
            io_d    = data_io;
            clr_d   = 1'b0;
            case (data_type[1:0])
              2'b00:   last_d = 2'd0;
              2'b01:   last_d = 2'd1;
              default: last_d = 2'd3;
            endcase
            if (data_wr) begin
              mem_wr_d   = 1'b1;
              mem_dout_d = data_value[7:0];
            end
`ifdef MEM_ARB_FAIR_EN
            lastg_d = 1'b1;
`endif
          end else if (!clear && inst_ok) begin
            state_d = INST_RD;
            addr_d  = inst_addr;
            mem_a_d = inst_addr;
            cnt_d   = 2'd0;
            last_d  = INST_LAST;
`ifdef MEM_ARB_FAIR_EN
            lastg_d = 1'b0;
`endif
          end
        end
        INST_RD: begin
          if (clear) begin
            state_d  = IDLE;
            mem_wr_d = 1'b0;
          end else begin
            res_d = asm_w;
            if (cnt_q == last_q) begin
              state_d      = IDLE;
              inst_ready_d = 1'b1;
              inst_res_d   = asm_w;
            end else begin
              cnt_d   = nxt;
              mem_a_d = addr_q + {30'h0, nxt};
            end
          end
        end
        DATA_RD: begin
          if (clear && !io_q) begin
            state_d  = IDLE;
            mem_wr_d = 1'b0;
          end else begin
            // IO reads have side effects, so they finish even when flushed.
            clr_d = clr_q | clear;
            res_d = asm_w;
            if (cnt_q == last_q) begin
              state_d      = IDLE;
              data_res_d   = ext_w;
              data_ready_d = !(clr_q || clear);
            end else begin
              cnt_d   = nxt;
              mem_a_d = addr_q + {30'h0, nxt};
            end
          end
        end
        DATA_WR: begin
          if (cnt_q == last_q) begin
            state_d      = IDLE;
            mem_wr_d     = 1'b0;
            data_ready_d = 1'b1;
          end else begin
            cnt_d      = nxt;
            mem_a_d    = addr_q + {30'h0, nxt};
            mem_dout_d = wdata_q[{nxt, 3'b000} +: 8];
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= 2'd0;
      last_q       <= 2'd0;
      size_q       <= 2'd0;
      sext_q       <= 1'b0;
      io_q         <= 1'b0;
      clr_q        <= 1'b0;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      res_q        <= 32'h0;
      mem_a_q      <= 32'h0;
      mem_dout_q   <= 8'h0;
      mem_wr_q     <= 1'b0;
      inst_ready_q <= 1'b0;
      data_ready_q <= 1'b0;
      inst_res_q   <= 32'h0;
      data_res_q   <= 32'h0;
`ifdef MEM_ARB_FAIR_EN
      lastg_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_q       <= last_d;
      size_q       <= size_d;
      sext_q       <= sext_d;
      io_q         <= io_d;
      clr_q        <= clr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      res_q        <= res_d;
      mem_a_q      <= mem_a_d;
      mem_dout_q   <= mem_dout_d;
      mem_wr_q     <= mem_wr_d;
      inst_ready_q <= inst_ready_d;
      data_ready_q <= data_ready_d;
      inst_res_q   <= inst_res_d;
      data_res_q   <= data_res_d;
`ifdef MEM_ARB_FAIR_EN
      lastg_q      <= lastg_d;
`endif
    end
  end

  assign mem_a      = mem_a_q;
  assign mem_dout   = mem_dout_q;
  assign mem_wr     = mem_wr_q;
  assign inst_ready = inst_ready_q;
  assign inst_res   = inst_res_q;
  assign data_ready = data_ready_q;
  assign data_res   = data_res_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: byte-addressed memory model keyed on mem_a[7:0].
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst, rdy, clear;
  logic        inst_valid, data_valid, data_wr, io_buffer_full;
  logic [31:0] inst_addr, data_addr, data_value;
  logic [2:0]  data_type;
  logic        inst_ready, data_ready, mem_wr;
  logic [31:0] inst_res, data_res, mem_a;
  logic [7:0]  mem_din, mem_dout;

  logic [7:0]  mem  [256];
  logic [7:0]  wmem [256];
  int          wr_cnt = 0;
  int          dr_cnt = 0;
  logic        dr_prev = 1'b0;
  int          total = 0;
  int          bad = 0;
  int          w0, d0;

  mem_arbiter dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .inst_valid(inst_valid), .inst_addr(inst_addr), .inst_ready(inst_ready), .inst_res(inst_res),
    .data_valid(data_valid), .data_wr(data_wr), .data_type(data_type), .data_addr(data_addr),
    .data_value(data_value), .data_ready(data_ready), .data_res(data_res),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk = ~clk;

  assign mem_din = mem[mem_a[7:0]];

  always @(posedge clk) begin
    if (rst && rdy && mem_wr) begin
      wmem[mem_a[7:0]] = mem_dout;
      wr_cnt = wr_cnt + 1;
    end
    if (data_ready && !dr_prev) dr_cnt = dr_cnt + 1;
    dr_prev = data_ready;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h13;
    mem[8'h04] = 8'h11; mem[8'h05] = 8'h22; mem[8'h06] = 8'h33; mem[8'h07] = 8'h44;
    mem[8'h10] = 8'hAA; mem[8'h11] = 8'hBB; mem[8'h12] = 8'hCC; mem[8'h13] = 8'hDD;
    mem[8'h80] = 8'h80; mem[8'h81] = 8'h90;

    rst = 1'b0; rdy = 1'b1; clear = 1'b0; io_buffer_full = 1'b0;
    inst_valid = 1'b0; inst_addr = 32'h0;
    data_valid = 1'b0; data_wr = 1'b0; data_type = 3'b000; data_addr = 32'h0; data_value = 32'h0;
    tick(); tick();
    chk("rst_mem_a", mem_a, 32'h0);
    chk("rst_mem_wr", {31'h0, mem_wr}, 32'h0);
    chk("rst_dout", {24'h0, mem_dout}, 32'h0);
    chk("rst_readies", {30'h0, inst_ready, data_ready}, 32'h0);
    chk("rst_results", inst_res | data_res, 32'h0);
    rst = 1'b1;
    tick();

    // word fetch: grant edge plus four sample edges
    inst_valid = 1'b1; inst_addr = 32'h1000;
    tick();
    chk("t1_mem_a", mem_a, 32'h1000);
    chk("t1_mem_wr", {31'h0, mem_wr}, 32'h0);
    tick(); tick(); tick();
    chk("t1_early", {31'h0, inst_ready}, 32'h0);
    tick();
    chk("t1_ready", {31'h0, inst_ready}, 32'h1);
    chk("t1_res", inst_res, 32'h00000013);
    chk("t1_mem_a_last", mem_a, 32'h1003);
    inst_valid = 1'b0;
    tick();
    chk("t1_drop", {31'h0, inst_ready}, 32'h0);

    // simultaneous requests: data first, then inst
    inst_valid = 1'b1; inst_addr = 32'h1004;
    data_valid = 1'b1; data_wr = 1'b0; data_type = 3'b010; data_addr = 32'h10;
    tick();
    chk("t2_data_first", mem_a, 32'h10);
    tick(); tick(); tick(); tick();
    chk("t2_dready", {30'h0, inst_ready, data_ready}, 32'h1);
    chk("t2_dres", data_res, 32'hDDCCBBAA);
    data_valid = 1'b0;
    tick();
    chk("t2_inst_grant", mem_a, 32'h1004);
    chk("t2_ddrop", {31'h0, data_ready}, 32'h0);
    tick(); tick(); tick(); tick();
    chk("t2_iready", {31'h0, inst_ready}, 32'h1);
    chk("t2_ires", inst_res, 32'h44332211);
    inst_valid = 1'b0;
    tick();

    // IO store held off by UART backpressure
    w0 = wr_cnt;
    data_valid = 1'b1; data_wr = 1'b1; data_type = 3'b000; data_addr = 32'h30000; data_value = 32'h41;
    io_buffer_full = 1'b1;
    tick(); tick(); tick();
    chk("t3_blocked", {31'h0, mem_wr}, 32'h0);
    chk("t3_no_writes", wr_cnt - w0, 0);
    io_buffer_full = 1'b0;
    tick();
    chk("t3_wr", {31'h0, mem_wr}, 32'h1);
    chk("t3_dout", {24'h0, mem_dout}, 32'h41);
    chk("t3_addr", mem_a, 32'h30000);
    tick();
    chk("t3_done", {30'h0, mem_wr, data_ready}, 32'h1);
    data_valid = 1'b0;
    chk("t3_count", wr_cnt - w0, 1);
    chk("t3_byte", {24'h0, wmem[8'h00]}, 32'h41);
    tick();

    // flush two cycles into a fetch
    inst_valid = 1'b1; inst_addr = 32'h1000;
    tick(); tick();
    clear = 1'b1; inst_valid = 1'b0;
    tick();
    clear = 1'b0;
    chk("t4_no_ready", {31'h0, inst_ready}, 32'h0);
    chk("t4_mem_wr", {31'h0, mem_wr}, 32'h0);
    tick(); tick(); tick();
    chk("t4_still_none", {31'h0, inst_ready}, 32'h0);
    inst_valid = 1'b1; inst_addr = 32'h1004;
    tick();
    chk("t4_idle_regrant", mem_a, 32'h1004);
    tick(); tick(); tick(); tick();
    chk("t4_ires", inst_res, 32'h44332211);
    inst_valid = 1'b0;
    tick();

    // sign/zero extension
    data_valid = 1'b1; data_wr = 1'b0; data_type = 3'b100; data_addr = 32'h2080;
    tick(); tick();
    chk("t5_lb_ready", {31'h0, data_ready}, 32'h1);
    chk("t5_lb", data_res, 32'hFFFFFF80);
    data_valid = 1'b0;
    tick();
    data_valid = 1'b1; data_type = 3'b000;
    tick(); tick();
    chk("t5_lbu", data_res, 32'h00000080);
    data_valid = 1'b0;
    tick();
    data_valid = 1'b1; data_type = 3'b101;
    tick(); tick();
    chk("t5_lh_early", {31'h0, data_ready}, 32'h0);
    tick();
    chk("t5_lh", data_res, 32'hFFFF9080);
    data_valid = 1'b0;
    tick();

    // rdy stall mid word store
    w0 = wr_cnt; d0 = dr_cnt;
    data_valid = 1'b1; data_wr = 1'b1; data_type = 3'b010; data_addr = 32'h40; data_value = 32'hA1B2C3D4;
    tick();
    chk("t6_b0", {mem_a[23:0], mem_dout}, 32'h000040D4);
    tick();
    rdy = 1'b0;
    tick(); tick(); tick();
    chk("t6_frozen", {mem_a[23:0], mem_dout}, 32'h000041C3);
    chk("t6_frozen_wr", {31'h0, mem_wr}, 32'h1);
    rdy = 1'b1;
    tick(); tick();
    chk("t6_b3", {mem_a[23:0], mem_dout}, 32'h000043A1);
    tick();
    chk("t6_ready", {30'h0, mem_wr, data_ready}, 32'h1);
    data_valid = 1'b0;
    tick(); tick();
    chk("t6_writes", wr_cnt - w0, 4);
    chk("t6_readies", dr_cnt - d0, 1);
    chk("t6_mem", {wmem[8'h43], wmem[8'h42], wmem[8'h41], wmem[8'h40]}, 32'hA1B2C3D4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
